// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared definitions for the branch-prediction controller:
//                2-bit counter state codes, the pipeline slot record and the
//                default table/statistics widths.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

  // 2-bit saturating counter states; bit [1] is the taken prediction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int IDX_BITS_DEF = 4;
  localparam int CNT_W_DEF    = 16;

  // Prediction record carried alongside an instruction through D and E.
  // The index field is sized by IDX_BITS_DEF; the controller's IDX_BITS
  // parameter has to match it.
  typedef struct packed {
    logic                    valid;
    logic [IDX_BITS_DEF-1:0] idx;
    logic                    pred;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/sat_cnt2.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt2
//  Description : Next state of a 2-bit saturating counter (SNT..ST).
//                Taken counts up and stops at ST; not-taken counts down and
//                stops at SNT.
//  Ports       : state_i  current counter state
//                taken_i  resolved branch outcome
//                state_o  updated counter state
//  Revision    : 1.0  initial release
// ============================================================================
module sat_cnt2
  import bp_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       taken_i,
  output logic [1:0] state_o
);

  always_comb begin
    state_o = state_i;
    if (taken_i) begin
      if (state_i != ST) state_o = state_i + 2'b01;
    end else begin
      if (state_i != SNT) state_o = state_i - 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pred_ctrl
//  Description : Direct-mapped table of 2-bit saturating counters. Predicts
//                fetched branches combinationally, carries the prediction
//                through D and E, updates the table on resolution, flags
//                mispredicts and keeps saturating hit/miss statistics.
//  Ports       : clk, reset (sync, active-low)
//                PCF, BranchF            fetch PC / branch marker
//                StallD, FlushD, FlushE  pipeline control
//                BranchTakenE            resolved outcome in E
//                StatClr                 clear both statistics counters
//                PredictTakenF           F-stage prediction
//                PredTakenE, MispredictE E-stage prediction / mispredict flag
//                BranchCount, MispredCount  saturating statistics
//  Revision    : 1.0  initial release
// ============================================================================
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCF,
  input  logic             BranchF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             BranchTakenE,
  input  logic             StatClr,
  output logic             PredictTakenF,
  output logic             PredTakenE,
  output logic             MispredictE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int               ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]          tbl_q [ENTRIES];
  slot_t               d_q, d_d;
  slot_t               e_q, e_d;
  logic [CNT_W-1:0]    bcnt_q, bcnt_d;
  logic [CNT_W-1:0]    mcnt_q, mcnt_d;

  logic [IDX_BITS-1:0] w_idx_f;
  logic [1:0]          w_upd_state;
  logic                w_pred_f;
  logic                w_mis_e;
  logic                w_unused_pc;

  assign w_idx_f     = PCF[IDX_BITS+1:2];
  assign w_unused_pc = ^{PCF[31:IDX_BITS+2], PCF[1:0]};

  // Combinational read of the registered table: an update landing on the
  // same edge is only visible from the following cycle.
  assign w_pred_f = BranchF & tbl_q[w_idx_f][1];
  assign w_mis_e  = e_q.valid & (BranchTakenE != e_q.pred);

  assign PredictTakenF = w_pred_f;
  assign PredTakenE    = e_q.valid & e_q.pred;
  assign MispredictE   = w_mis_e;
  assign BranchCount   = bcnt_q;
  assign MispredCount  = mcnt_q;

  sat_cnt2 u_sat_cnt2 (
    .state_i (tbl_q[e_q.idx]),
    .taken_i (BranchTakenE),
    .state_o (w_upd_state)
  );

  always_comb begin
    d_d    = d_q;
    e_d    = d_q;
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;

    if (!StallD) begin
      d_d.valid = BranchF;
      d_d.idx   = w_idx_f;
      d_d.pred  = w_pred_f;
    end
    // A mispredict squashes the younger instructions in both slots;
    // clearing wins over both load and hold.
    if (FlushD || w_mis_e) d_d.valid = 1'b0;
    if (FlushE || w_mis_e) e_d.valid = 1'b0;

    if (StatClr) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end else begin
      if (e_q.valid && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_ONE;
      if (w_mis_e && (mcnt_q != '1))   mcnt_d = mcnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= WNT;
      d_q    <= '0;
      e_q    <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      d_q    <= d_d;
      e_q    <= e_d;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
      if (e_q.valid) tbl_q[e_q.idx] <= w_upd_state;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_pred_ctrl
//  Description : Self-checking bench for branch_pred_ctrl. Two instances
//                (16-bit and 4-bit statistics) share one stimulus stream;
//                a behavioural model tracks table, slots and counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_pred_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PCF = '0;
  logic        BranchF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0;
  logic        BranchTakenE = 1'b0, StatClr = 1'b0;

  logic        pf16, pe16, mis16, pf4, pe4, mis4;
  logic [15:0] bc16, mc16;
  logic [3:0]  bc4, mc4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_pred_ctrl dut (
    .clk(clk), .reset(reset), .PCF(PCF), .BranchF(BranchF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .BranchTakenE(BranchTakenE),
    .StatClr(StatClr), .PredictTakenF(pf16), .PredTakenE(pe16),
    .MispredictE(mis16), .BranchCount(bc16), .MispredCount(mc16)
  );

  branch_pred_ctrl #(.IDX_BITS(4), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .PCF(PCF), .BranchF(BranchF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .BranchTakenE(BranchTakenE),
    .StatClr(StatClr), .PredictTakenF(pf4), .PredTakenE(pe4),
    .MispredictE(mis4), .BranchCount(bc4), .MispredCount(mc4)
  );

  // ---------------- behavioural reference model ----------------
  int mtbl[16];
  bit m_dv, m_ev, m_dp, m_ep;
  int m_di, m_ei;
  int m_bc, m_mc, m_bc4, m_mc4;
  bit model_ok = 0;

  function automatic int sat_inc(int v, int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int  ix;
    bit  epf, epe, emis;
    ix   = int'(PCF[5:2]);
    epf  = BranchF && (mtbl[ix] >= 2);
    epe  = m_ev && m_ep;
    emis = m_ev && (BranchTakenE != m_ep);
    chk1("m_pf16",  {31'b0, pf16},  {31'b0, epf});
    chk1("m_pe16",  {31'b0, pe16},  {31'b0, epe});
    chk1("m_mis16", {31'b0, mis16}, {31'b0, emis});
    chk1("m_bc16",  {16'b0, bc16},  m_bc);
    chk1("m_mc16",  {16'b0, mc16},  m_mc);
    chk1("m_pf4",   {31'b0, pf4},   {31'b0, epf});
    chk1("m_mis4",  {31'b0, mis4},  {31'b0, emis});
    chk1("m_pe4",   {31'b0, pe4},   {31'b0, epe});
    chk1("m_bc4",   {28'b0, bc4},   m_bc4);
    chk1("m_mc4",   {28'b0, mc4},   m_mc4);
  endtask

  task automatic model_step();
    int ix;
    bit pf, mis;
    bit ndv, ndp, nev;
    int ndi;
    if (!reset) begin
      for (int i = 0; i < 16; i++) mtbl[i] = 1;
      m_dv = 0; m_ev = 0; m_dp = 0; m_ep = 0; m_di = 0; m_ei = 0;
      m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      model_ok = 1;
    end else begin
      ix  = int'(PCF[5:2]);
      pf  = BranchF && (mtbl[ix] >= 2);   // read before this edge's update
      mis = m_ev && (BranchTakenE != m_ep);
      if (m_ev) begin
        mtbl[m_ei] = BranchTakenE ? ((mtbl[m_ei] < 3) ? mtbl[m_ei] + 1 : 3)
                                  : ((mtbl[m_ei] > 0) ? mtbl[m_ei] - 1 : 0);
        m_bc  = sat_inc(m_bc, 65535);
        m_bc4 = sat_inc(m_bc4, 15);
        if (mis) begin
          m_mc  = sat_inc(m_mc, 65535);
          m_mc4 = sat_inc(m_mc4, 15);
        end
      end
      if (StatClr) begin
        m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      end
      nev = m_dv && !FlushE && !mis;
      ndv = m_dv; ndi = m_di; ndp = m_dp;
      if (!StallD) begin
        ndv = BranchF; ndi = ix; ndp = pf;
      end
      if (FlushD || mis) ndv = 0;
      m_ev = nev; m_ei = m_di; m_ep = m_dp;
      m_dv = ndv; m_di = ndi; m_dp = ndp;
    end
  endtask

  task automatic half_check();
    @(negedge clk);
    if (model_ok) model_check();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          r;
    logic [31:0] pc;
    bit          bf, st, fd, fe, tk, sc;
    bit          chk;
    bit          pf, pe, mis;
    int          bc, mc;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(bit r, logic [31:0] pc, bit bf, bit st, bit fd,
                               bit fe, bit tk, bit sc, bit chk, bit pf, bit pe,
                               bit mis, int bc, int mc);
    vec_t v;
    v = '{r, pc, bf, st, fd, fe, tk, sc, chk, pf, pe, mis, bc, mc};
    vecs.push_back(v);
  endfunction

  task automatic drive(input bit r, input logic [31:0] pc, input bit bf,
                       input bit st, input bit fd, input bit fe, input bit tk,
                       input bit sc);
    reset = r; PCF = pc; BranchF = bf; StallD = st;
    FlushD = fd; FlushE = fe; BranchTakenE = tk; StatClr = sc;
  endtask

  initial begin
    //   r  pc     bf st fd fe tk sc chk pf pe mis bc  mc
    addv(0, 'h00,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0);  // reset
    addv(0, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0,  0);  // reset state
    addv(1, 'h10,  1, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0,  0);  // fetch idx 4 (WNT)
    addv(1, 'h10,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0,  0);
    addv(1, 'h00,  0, 0, 0, 0, 1, 0, 1,  0, 0, 1,  0,  0);  // taken -> mispredict
    addv(1, 'h10,  1, 0, 0, 0, 1, 0, 1,  1, 0, 0,  1,  1);  // entry now WT
    addv(1, 'h10,  1, 0, 0, 0, 1, 0, 1,  1, 0, 0,  1,  1);
    addv(1, 'h10,  1, 0, 0, 0, 1, 0, 1,  1, 1, 0,  1,  1);
    addv(1, 'h10,  1, 0, 0, 0, 1, 0, 1,  1, 1, 0,  2,  1);  // ST reached
    addv(1, 'h00,  0, 0, 0, 0, 1, 0, 1,  0, 1, 0,  3,  1);
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 1, 1,  4,  1);  // not-taken on ST
    addv(1, 'h10,  1, 0, 0, 0, 0, 0, 1,  1, 0, 0,  5,  2);  // back to WT
    addv(1, 'h00,  0, 1, 0, 0, 1, 0, 1,  0, 0, 0,  5,  2);  // stall D
    addv(1, 'h00,  0, 1, 0, 0, 1, 0, 1,  0, 1, 0,  5,  2);
    addv(1, 'h00,  0, 1, 0, 0, 1, 0, 1,  0, 1, 0,  6,  2);
    addv(1, 'h00,  0, 1, 1, 0, 1, 0, 1,  0, 1, 0,  7,  2);  // flush + stall
    addv(1, 'h00,  0, 0, 0, 0, 1, 0, 1,  0, 1, 0,  8,  2);
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  9,  2);  // nothing follows
    addv(1, 'h10,  1, 0, 0, 0, 0, 0, 1,  1, 0, 0,  9,  2);  // branch A (ST)
    addv(1, 'h14,  1, 0, 0, 0, 0, 0, 1,  0, 0, 0,  9,  2);  // branch B idx 5
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 1, 1,  9,  2);  // A mispredicts
    addv(1, 'h00,  0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 10,  3);  // B squashed
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10,  3);
    addv(1, 'h10,  1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 10,  3);  // idx 4 is WT
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10,  3);
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 10,  3);  // WT -> WNT
    addv(1, 'h10,  1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 11,  4);
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 11,  4);
    addv(1, 'h10,  1, 0, 0, 0, 1, 0, 1,  0, 0, 1, 11,  4);  // update+read same idx
    addv(1, 'h10,  1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 12,  5);  // now sees WT
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 12,  5);
    addv(1, 'h00,  0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 12,  5);  // StatClr + resolve
    addv(1, 'h00,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0,  0,  0);

    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].pc, vecs[k].bf, vecs[k].st, vecs[k].fd,
            vecs[k].fe, vecs[k].tk, vecs[k].sc);
      half_check();
      if (vecs[k].chk) begin
        chk1($sformatf("v%0d_pf", k),  {31'b0, pf16},  {31'b0, vecs[k].pf});
        chk1($sformatf("v%0d_pe", k),  {31'b0, pe16},  {31'b0, vecs[k].pe});
        chk1($sformatf("v%0d_mis", k), {31'b0, mis16}, {31'b0, vecs[k].mis});
        chk1($sformatf("v%0d_bc", k),  {16'b0, bc16},  vecs[k].bc);
        chk1($sformatf("v%0d_mc", k),  {16'b0, mc16},  vecs[k].mc);
      end
      clock_edge();
    end

    // 20 correctly predicted not-taken branches at idx 8; 4-bit stats saturate
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h20, 1, 0, 0, 0, 0, 0);
      half_check();
      clock_edge();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h0, 0, 0, 0, 0, 0, 0);
      half_check();
      clock_edge();
    end
    half_check();
    chk1("sat_bc4",  {28'b0, bc4},  32'd15);
    chk1("sat_bc16", {16'b0, bc16}, 32'd20);
    chk1("sat_mc4",  {28'b0, mc4},  32'd0);
    clock_edge();

    // StatClr together with a valid resolution
    drive(1, 32'h20, 1, 0, 0, 0, 0, 0); half_check(); clock_edge();
    drive(1, 32'h0,  0, 0, 0, 0, 0, 0); half_check(); clock_edge();
    drive(1, 32'h0,  0, 0, 0, 0, 0, 1); half_check(); clock_edge();
    drive(1, 32'h0,  0, 0, 0, 0, 0, 0); half_check();
    chk1("clr_bc4",  {28'b0, bc4},  32'd0);
    chk1("clr_bc16", {16'b0, bc16}, 32'd0);
    clock_edge();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rv;
      logic [1:0]  ix2;
      rv  = $urandom;
      ix2 = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 99) >= 2,
            {rv[31:4], ix2, rv[1:0]},
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 2);
      half_check();
      clock_edge();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
